// File: rtl/cpu_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : cpu_ctrl_pkg
//  Description : Shared state encoding, opcode and ALU-op constants for the
//                multi-cycle RV64 main control FSM.
//  Revision    : 1.0  initial release
// ============================================================================
package cpu_ctrl_pkg;

    typedef enum logic [2:0] {
        FETCH  = 3'd0,
        DECODE = 3'd1,
        EXEC   = 3'd2,
        MEM    = 3'd3,
        WB     = 3'd4,
        TRAP   = 3'd5
    } ctrl_state_t;

    localparam logic [6:0] OP_LD  = 7'b0000011;
    localparam logic [6:0] OP_SD  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_BEQ = 7'b1100011;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

endpackage
`default_nettype wire

// File: rtl/ctrl_opcode_decode.sv
`default_nettype none
// ============================================================================
//  Module      : ctrl_opcode_decode
//  Description : Combinational classification of the latched opcode into the
//                four supported instruction classes plus an illegal flag.
//  Revision    : 1.0  initial release
// ============================================================================
module ctrl_opcode_decode
    import cpu_ctrl_pkg::*;
(
    input  logic [6:0] opcode,
    output logic       is_ld,
    output logic       is_sd,
    output logic       is_r,
    output logic       is_beq,
    output logic       illegal
);

    always_comb begin
        is_ld   = (opcode == OP_LD);
        is_sd   = (opcode == OP_SD);
        is_r    = (opcode == OP_R);
        is_beq  = (opcode == OP_BEQ);
        illegal = !(is_ld || is_sd || is_r || is_beq);
    end

endmodule
`default_nettype wire

// File: rtl/multi_cycle_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : multi_cycle_ctrl
//  Description : Multi-cycle main control FSM sequencing FETCH/DECODE/EXEC/
//                MEM/WB with memory ready handshakes, halt and sticky trap.
//  Revision    : 1.0  initial release
// ============================================================================
module multi_cycle_ctrl
    import cpu_ctrl_pkg::*;
#(
    parameter int CNT_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [6:0]           inst_opcode,
    input  logic                 alu_zero,
    input  logic                 imem_ready,
    input  logic                 dmem_ready,
    input  logic                 halt_req,
    output logic                 imem_req,
    output logic                 ir_write,
    output logic                 pc_write,
    output logic                 pc_sel,
    output logic                 alu_src,
    output logic [1:0]           alu_op,
    output logic                 mem_read,
    output logic                 mem_write,
    output logic                 mem_to_reg,
    output logic                 reg_write,
    output logic                 halted,
    output logic                 trap,
    output logic [CNT_WIDTH-1:0] inst_retired
);

    ctrl_state_t          state_q, state_d;
    logic [6:0]           opcode_q, opcode_d;
    logic                 trap_q, trap_d;
    logic [CNT_WIDTH-1:0] retired_q, retired_d;

    logic w_is_ld, w_is_sd, w_is_r, w_is_beq, w_illegal;
    logic w_retire;
    logic w_imem_req, w_ir_write, w_pc_write, w_pc_sel, w_alu_src;
    logic w_mem_read, w_mem_write, w_mem_to_reg, w_reg_write, w_halted;
    logic [1:0] w_alu_op;

    ctrl_opcode_decode u_decode (
        .opcode  (opcode_q),
        .is_ld   (w_is_ld),
        .is_sd   (w_is_sd),
        .is_r    (w_is_r),
        .is_beq  (w_is_beq),
        .illegal (w_illegal)
    );

    always_comb begin
        state_d      = state_q;
        opcode_d     = opcode_q;
        trap_d       = trap_q;
        w_retire     = 1'b0;
        w_imem_req   = 1'b0;
        w_ir_write   = 1'b0;
        w_pc_write   = 1'b0;
        w_pc_sel     = 1'b0;
        w_alu_src    = 1'b0;
        w_alu_op     = ALUOP_ADD;
        w_mem_read   = 1'b0;
        w_mem_write  = 1'b0;
        w_mem_to_reg = 1'b0;
        w_reg_write  = 1'b0;
        w_halted     = 1'b0;

        case (state_q)
            FETCH: begin
                // A halt request masks imem_ready so no instruction is latched.
                if (halt_req) begin
                    w_halted = 1'b1;
                end else begin
                    w_imem_req = 1'b1;
                    if (imem_ready) begin
                        w_ir_write = 1'b1;
                        opcode_d   = inst_opcode;
                        state_d    = DECODE;
                    end
                end
            end
            DECODE: begin
                if (w_illegal) begin
                    trap_d  = 1'b1;
                    state_d = TRAP;
                end else begin
                    state_d = EXEC;
                end
            end
            EXEC: begin
                if (w_is_ld || w_is_sd) begin
                    w_alu_src = 1'b1;
                    state_d   = MEM;
                end else if (w_is_r) begin
                    w_alu_op = ALUOP_FUNCT;
                    state_d  = WB;
                end else if (w_is_beq) begin
                    w_alu_op   = ALUOP_SUB;
                    w_pc_write = 1'b1;
                    w_pc_sel   = alu_zero;
                    w_retire   = 1'b1;
                    state_d    = FETCH;
                end else begin
                    trap_d  = 1'b1;
                    state_d = TRAP;
                end
            end
            MEM: begin
                w_alu_src   = 1'b1;
                w_mem_read  = w_is_ld;
                w_mem_write = w_is_sd;
                if (dmem_ready) begin
                    if (w_is_ld) begin
                        state_d = WB;
                    end else begin
                        w_pc_write = 1'b1;
                        w_retire   = 1'b1;
                        state_d    = FETCH;
                    end
                end
            end
            WB: begin
                w_reg_write  = 1'b1;
                w_mem_to_reg = w_is_ld;
                w_pc_write   = 1'b1;
                w_retire     = 1'b1;
                state_d      = FETCH;
            end
            TRAP: begin
                state_d = TRAP;
            end
            default: begin
                state_d = FETCH;
            end
        endcase

        retired_d = retired_q + {{(CNT_WIDTH-1){1'b0}}, w_retire};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= FETCH;
            opcode_q  <= 7'd0;
            trap_q    <= 1'b0;
            retired_q <= '0;
        end else begin
            state_q   <= state_d;
            opcode_q  <= opcode_d;
            trap_q    <= trap_d;
            retired_q <= retired_d;
        end
    end

    // Reset gates every strobe so a mid-instruction reset cannot commit state.
    assign imem_req     = w_imem_req   & ~reset;
    assign ir_write     = w_ir_write   & ~reset;
    assign pc_write     = w_pc_write   & ~reset;
    assign pc_sel       = w_pc_sel     & ~reset;
    assign alu_src      = w_alu_src    & ~reset;
    assign alu_op       = reset ? ALUOP_ADD : w_alu_op;
    assign mem_read     = w_mem_read   & ~reset;
    assign mem_write    = w_mem_write  & ~reset;
    assign mem_to_reg   = w_mem_to_reg & ~reset;
    assign reg_write    = w_reg_write  & ~reset;
    assign halted       = w_halted     & ~reset;
    assign trap         = trap_q;
    assign inst_retired = retired_q;

endmodule
`default_nettype wire

// File: tb/tb_multi_cycle_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_multi_cycle_ctrl
//  Description : Self-checking bench; expected per-cycle strobe traces are
//                built from per-instruction rules and compared every cycle.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_multi_cycle_ctrl;

    localparam int CNT_WIDTH = 32;

    localparam logic [6:0] C_OP_LD  = 7'b0000011;
    localparam logic [6:0] C_OP_SD  = 7'b0100011;
    localparam logic [6:0] C_OP_R   = 7'b0110011;
    localparam logic [6:0] C_OP_BEQ = 7'b1100011;

    // Bit positions of the observed strobe vector
    localparam logic [11:0] B_IMEM  = 12'h800;
    localparam logic [11:0] B_IR    = 12'h400;
    localparam logic [11:0] B_PCW   = 12'h200;
    localparam logic [11:0] B_PCS   = 12'h100;
    localparam logic [11:0] B_SRC   = 12'h080;
    localparam logic [11:0] B_FUNCT = 12'h040;
    localparam logic [11:0] B_SUB   = 12'h020;
    localparam logic [11:0] B_MR    = 12'h010;
    localparam logic [11:0] B_MW    = 12'h008;
    localparam logic [11:0] B_M2R   = 12'h004;
    localparam logic [11:0] B_RW    = 12'h002;
    localparam logic [11:0] B_HALT  = 12'h001;

    logic                 clk = 1'b0;
    logic                 reset = 1'b1;
    logic [6:0]           inst_opcode = 7'd0;
    logic                 alu_zero = 1'b0;
    logic                 imem_ready = 1'b0;
    logic                 dmem_ready = 1'b0;
    logic                 halt_req = 1'b0;
    logic                 imem_req, ir_write, pc_write, pc_sel, alu_src;
    logic [1:0]           alu_op;
    logic                 mem_read, mem_write, mem_to_reg, reg_write, halted, trap;
    logic [CNT_WIDTH-1:0] inst_retired;

    int                   vectors = 0;
    int                   miscompares = 0;
    logic [CNT_WIDTH-1:0] model_cnt = '0;
    logic [11:0]          exp_q[$];
    logic [2:0]           in_q[$];

    wire [11:0] obs = {imem_req, ir_write, pc_write, pc_sel, alu_src, alu_op,
                       mem_read, mem_write, mem_to_reg, reg_write, halted};

    multi_cycle_ctrl #(.CNT_WIDTH(CNT_WIDTH)) dut (
        .clk          (clk),
        .reset        (reset),
        .inst_opcode  (inst_opcode),
        .alu_zero     (alu_zero),
        .imem_ready   (imem_ready),
        .dmem_ready   (dmem_ready),
        .halt_req     (halt_req),
        .imem_req     (imem_req),
        .ir_write     (ir_write),
        .pc_write     (pc_write),
        .pc_sel       (pc_sel),
        .alu_src      (alu_src),
        .alu_op       (alu_op),
        .mem_read     (mem_read),
        .mem_write    (mem_write),
        .mem_to_reg   (mem_to_reg),
        .reg_write    (reg_write),
        .halted       (halted),
        .trap         (trap),
        .inst_retired (inst_retired)
    );

    always #5 clk = ~clk;

    function automatic logic rb();
        return 1'($urandom_range(0, 1));
    endfunction

    function automatic logic is_legal(input logic [6:0] op);
        return (op == C_OP_LD) || (op == C_OP_SD) || (op == C_OP_R) || (op == C_OP_BEQ);
    endfunction

    // Expected trace from instruction rules; inputs are {imem_ready, dmem_ready, alu_zero}.
    task automatic build(input logic [6:0] op, input int wi, input int wd, input logic z);
        exp_q.delete();
        in_q.delete();
        repeat (wi) begin exp_q.push_back(B_IMEM); in_q.push_back({1'b0, rb(), rb()}); end
        exp_q.push_back(B_IMEM | B_IR); in_q.push_back({1'b1, rb(), rb()});
        exp_q.push_back(12'h000);       in_q.push_back({rb(), rb(), rb()});
        case (op)
            C_OP_BEQ: begin
                exp_q.push_back(B_PCW | B_SUB | (z ? B_PCS : 12'h000));
                in_q.push_back({rb(), rb(), z});
            end
            C_OP_R: begin
                exp_q.push_back(B_FUNCT);            in_q.push_back({rb(), rb(), rb()});
                exp_q.push_back(B_RW | B_PCW);       in_q.push_back({rb(), rb(), rb()});
            end
            C_OP_LD: begin
                exp_q.push_back(B_SRC); in_q.push_back({rb(), rb(), rb()});
                repeat (wd) begin exp_q.push_back(B_SRC | B_MR); in_q.push_back({rb(), 1'b0, rb()}); end
                exp_q.push_back(B_SRC | B_MR);       in_q.push_back({rb(), 1'b1, rb()});
                exp_q.push_back(B_RW | B_M2R | B_PCW); in_q.push_back({rb(), rb(), rb()});
            end
            C_OP_SD: begin
                exp_q.push_back(B_SRC); in_q.push_back({rb(), rb(), rb()});
                repeat (wd) begin exp_q.push_back(B_SRC | B_MW); in_q.push_back({rb(), 1'b0, rb()}); end
                exp_q.push_back(B_SRC | B_MW | B_PCW); in_q.push_back({rb(), 1'b1, rb()});
            end
            default: ;
        endcase
    endtask

    task automatic run_instr(input string name, input logic [6:0] op, input int wi,
                             input int wd, input logic z);
        build(op, wi, wd, z);
        for (int i = 0; i < exp_q.size(); i++) begin
            {imem_ready, dmem_ready, alu_zero} = in_q[i];
            inst_opcode = (i == wi) ? op : 7'($urandom);
            @(negedge clk);
            vectors++;
            if (obs !== exp_q[i]) begin
                miscompares++;
                $display("FAIL %s cycle %0d: strobes %h, expected %h", name, i, obs, exp_q[i]);
            end
            @(posedge clk); #1;
        end
        if (is_legal(op)) model_cnt = model_cnt + 1'b1;
        vectors++;
        if (inst_retired !== model_cnt || trap !== !is_legal(op)) begin
            miscompares++;
            $display("FAIL %s retire: count %0d trap %b, expected count %0d trap %b",
                     name, inst_retired, trap, model_cnt, !is_legal(op));
        end
    endtask

    task automatic apply_reset(input int cycles);
        reset = 1'b1;
        repeat (cycles) begin
            imem_ready = rb(); dmem_ready = rb(); halt_req = rb();
            @(negedge clk);
            vectors++;
            if (obs !== 12'h000) begin
                miscompares++;
                $display("FAIL reset_strobes: strobes %h, expected 000", obs);
            end
            @(posedge clk); #1;
        end
        reset = 1'b0; halt_req = 1'b0; imem_ready = 1'b0;
        model_cnt = '0;
        vectors++;
        if (inst_retired !== model_cnt || trap !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_state: count %0d trap %b, expected 0 0", inst_retired, trap);
        end
    endtask

    task automatic test_reset();
        @(posedge clk); #1;
        apply_reset(2);
        @(negedge clk);
        vectors++;
        if (obs !== B_IMEM) begin
            miscompares++;
            $display("FAIL reset_fetch: strobes %h, expected %h", obs, B_IMEM);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_basic();
        run_instr("r_type", C_OP_R, 0, 0, 1'b0);
        run_instr("ld_wait", C_OP_LD, 0, 2, 1'b0);
        run_instr("beq_taken", C_OP_BEQ, 0, 0, 1'b1);
        run_instr("beq_not_taken", C_OP_BEQ, 0, 0, 1'b0);
        run_instr("sd", C_OP_SD, 1, 0, 1'b0);
    endtask

    task automatic test_halt();
        halt_req = 1'b1;
        repeat (4) begin
            imem_ready = 1'b1;
            inst_opcode = C_OP_R;
            @(negedge clk);
            vectors++;
            if (obs !== B_HALT || inst_retired !== model_cnt) begin
                miscompares++;
                $display("FAIL halt: strobes %h count %0d, expected %h count %0d",
                         obs, inst_retired, B_HALT, model_cnt);
            end
            @(posedge clk); #1;
        end
        halt_req = 1'b0;
        run_instr("after_halt", C_OP_BEQ, 0, 0, 1'b1);
    endtask

    task automatic test_reset_mid_ld();
        inst_opcode = C_OP_LD; imem_ready = 1'b1; dmem_ready = 1'b0;
        @(posedge clk); #1;
        imem_ready = 1'b0;
        repeat (2) begin @(posedge clk); #1; end
        @(negedge clk);
        vectors++;
        if (obs !== (B_SRC | B_MR)) begin
            miscompares++;
            $display("FAIL mid_ld_mem: strobes %h, expected %h", obs, B_SRC | B_MR);
        end
        apply_reset(3);
        run_instr("after_mid_reset", C_OP_R, 0, 0, 1'b0);
    endtask

    task automatic test_random();
        logic [6:0] ops [4];
        ops[0] = C_OP_LD; ops[1] = C_OP_SD; ops[2] = C_OP_R; ops[3] = C_OP_BEQ;
        for (int n = 0; n < 40; n++)
            run_instr("random", ops[$urandom_range(0, 3)], $urandom_range(0, 3),
                      $urandom_range(0, 3), rb());
    endtask

    task automatic test_trap(input logic [6:0] op);
        run_instr("trap_entry", op, $urandom_range(0, 2), 0, 1'b0);
        repeat (5) begin
            imem_ready = rb(); dmem_ready = rb(); halt_req = rb(); alu_zero = rb();
            @(negedge clk);
            vectors++;
            if (obs !== 12'h000 || trap !== 1'b1) begin
                miscompares++;
                $display("FAIL trap_hold: strobes %h trap %b, expected 000 1", obs, trap);
            end
            @(posedge clk); #1;
        end
        apply_reset(1);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_halt();
        test_random();
        test_reset_mid_ld();
        test_trap(7'b0010011);
        run_instr("after_trap", C_OP_SD, 0, 1, 1'b0);
        test_trap(7'b1111111);
        run_instr("back_to_back", C_OP_LD, 0, 0, 1'b0);
        run_instr("back_to_back", C_OP_LD, 2, 0, 1'b0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
